// File: rtl/seg_595_pkg.sv
// Shared types and helpers for the 74HC595 seven-segment scan driver.
package seg_595_pkg;

  localparam logic [7:0] SEG_OFF = 8'hFF;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SHIFT,
    ST_LATCH
  } scan_state_e;

  typedef enum logic [1:0] {
    SER_IDLE,
    SER_SHIFT,
    SER_LATCH
  } ser_state_e;

  // Common-anode, active-low segment codes; bit 7 (dp) is left off.
  function automatic logic [7:0] hex2seg(input logic [3:0] nib);
    logic [7:0] s;
    case (nib)
      4'h0: s = 8'hC0;
      4'h1: s = 8'hF9;
      4'h2: s = 8'hA4;
      4'h3: s = 8'hB0;
      4'h4: s = 8'h99;
      4'h5: s = 8'h92;
      4'h6: s = 8'h82;
      4'h7: s = 8'hF8;
      4'h8: s = 8'h80;
      4'h9: s = 8'h90;
      4'hA: s = 8'h88;
      4'hB: s = 8'h83;
      4'hC: s = 8'hC6;
      4'hD: s = 8'hA1;
      4'hE: s = 8'h86;
      default: s = 8'h8E;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/hc595_ser.sv
// Generic W-bit serialiser for a 595 chain: shifts frame LSB first, then pulses stcp.
module hc595_ser
  import seg_595_pkg::*;
#(
  parameter int unsigned W        = 14,
  parameter int unsigned SHCP_DIV = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] frame_i,
  input  logic         start_i,
  output logic         busy_o,
  output logic         ds_o,
  output logic         shcp_o,
  output logic         stcp_o
);

  localparam int unsigned HALF  = SHCP_DIV / 2;
  localparam int unsigned CNT_W = (SHCP_DIV > 1) ? $clog2(SHCP_DIV) : 1;
  localparam int unsigned BIT_W = (W > 1) ? $clog2(W) : 1;

  ser_state_e       state_q, state_d;
  logic [W-1:0]     sh_q, sh_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [BIT_W-1:0] bit_q, bit_d;
  logic             busy_q, busy_d;
  logic             ds_q, ds_d;
  logic             shcp_q, shcp_d;
  logic             stcp_q, stcp_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= SER_IDLE;
      sh_q    <= '0;
      cnt_q   <= '0;
      bit_q   <= '0;
      busy_q  <= 1'b0;
      ds_q    <= 1'b0;
      shcp_q  <= 1'b0;
      stcp_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      busy_q  <= busy_d;
      ds_q    <= ds_d;
      shcp_q  <= shcp_d;
      stcp_q  <= stcp_d;
    end
  end

  // Each bit: ds presented with shcp low, shcp high for the second half of the bit.
  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    ds_d    = ds_q;
    shcp_d  = shcp_q;
    stcp_d  = stcp_q;
    case (state_q)
      SER_IDLE: begin
        if (start_i) begin
          state_d = SER_SHIFT;
          ds_d    = frame_i[0];
          sh_d    = frame_i >> 1;
          cnt_d   = '0;
          bit_d   = '0;
          shcp_d  = 1'b0;
        end
      end
      SER_SHIFT: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(HALF - 1)) shcp_d = 1'b1;
        if (cnt_q == CNT_W'(SHCP_DIV - 1)) begin
          cnt_d  = '0;
          shcp_d = 1'b0;
          if (bit_q == BIT_W'(W - 1)) begin
            state_d = SER_LATCH;
            stcp_d  = 1'b1;
            ds_d    = 1'b0;
          end else begin
            bit_d = bit_q + BIT_W'(1);
            ds_d  = sh_q[0];
            sh_d  = sh_q >> 1;
          end
        end
      end
      SER_LATCH: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(HALF - 1)) begin
          stcp_d  = 1'b0;
          state_d = SER_IDLE;
        end
      end
      default: state_d = SER_IDLE;
    endcase
    busy_d = (state_d != SER_IDLE);
  end

  assign busy_o = busy_q;
  assign ds_o   = ds_q;
  assign shcp_o = shcp_q;
  assign stcp_o = stcp_q;

endmodule

// File: rtl/seg_595_scan.sv
// Multi-digit 7-segment scan driver: dwell timer, digit rotation, decode with
// leading-zero suppression, and output-enable gating for a 595 chain.
module seg_595_scan
  import seg_595_pkg::*;
#(
  parameter int unsigned DIG_NUM  = 6,
  parameter int unsigned CLK_FREQ = 50_000_000,
  parameter int unsigned SCAN_HZ  = 1000,
  parameter int unsigned SHCP_DIV = 4
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst_n,
  input  logic [4*DIG_NUM-1:0] data,
  input  logic [DIG_NUM-1:0]   point,
  input  logic                 lz_en,
  input  logic                 blank,
  output logic                 ds,
  output logic                 shcp,
  output logic                 stcp,
  output logic                 oe
);

  localparam int unsigned W       = 8 + DIG_NUM;
  localparam int unsigned DWELL   = CLK_FREQ / SCAN_HZ;
  localparam int unsigned DWELL_W = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam int unsigned IDX_W   = (DIG_NUM > 1) ? $clog2(DIG_NUM) : 1;

  if (DIG_NUM < 1 || DIG_NUM > 8) begin : g_bad_dig
    $error("seg_595_scan: DIG_NUM must be 1..8");
  end
  if (SHCP_DIV < 2 || (SHCP_DIV % 2) != 0) begin : g_bad_div
    $error("seg_595_scan: SHCP_DIV must be even and >= 2");
  end
  if (1 + (W + 1) * (SHCP_DIV / 2) * 2 >= DWELL) begin : g_bad_dwell
    $error("seg_595_scan: DWELL too short for one frame shift and latch");
  end

  scan_state_e        state_q, state_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               seen_q, seen_d;
  logic               oe_q, oe_d;

  logic               tick_c;
  logic               start_c;
  logic               nz_c;
  logic [7:0]         seg_c;
  logic [DIG_NUM-1:0] sel_c;
  logic [W-1:0]       frame_c;
  logic               busy_w;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q <= ST_IDLE;
      dwell_q <= '0;
      idx_q   <= '0;
      seen_q  <= 1'b0;
      oe_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      dwell_q <= dwell_d;
      idx_q   <= idx_d;
      seen_q  <= seen_d;
      oe_q    <= oe_d;
    end
  end

  // Digit frame for the current index; only consumed in the LOAD cycle.
  always_comb begin
    nz_c = 1'b0;
    for (int k = 0; k < int'(DIG_NUM); k++) begin
      if (k >= int'(idx_q) && data[4*k +: 4] != 4'h0) nz_c = 1'b1;
    end
    seg_c = hex2seg(data[4*int'(idx_q) +: 4]);
    if (lz_en && idx_q != '0 && !nz_c) seg_c[6:0] = SEG_OFF[6:0];
    seg_c[7] = ~point[idx_q];
    sel_c    = DIG_NUM'(1) << idx_q;
    frame_c  = {seg_c, sel_c};
  end

  // Scan sequencer; oe stays dark until the first complete latch.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    seen_d  = seen_q;
    start_c = 1'b0;
    tick_c  = (dwell_q == DWELL_W'(DWELL - 1));
    dwell_d = tick_c ? '0 : dwell_q + DWELL_W'(1);
    case (state_q)
      ST_IDLE:  if (tick_c) state_d = ST_LOAD;
      ST_LOAD: begin
        start_c = 1'b1;
        state_d = ST_SHIFT;
      end
      ST_SHIFT: if (stcp) state_d = ST_LATCH;
      ST_LATCH: begin
        if (!busy_w) begin
          state_d = ST_IDLE;
          seen_d  = 1'b1;
          idx_d   = (idx_q == IDX_W'(DIG_NUM - 1)) ? '0 : idx_q + IDX_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
    oe_d = seen_d ? blank : 1'b1;
  end

  hc595_ser #(
    .W        (W),
    .SHCP_DIV (SHCP_DIV)
  ) u_ser (
    .clk     (sys_clk),
    .rst_n   (sys_rst_n),
    .frame_i (frame_c),
    .start_i (start_c),
    .busy_o  (busy_w),
    .ds_o    (ds),
    .shcp_o  (shcp),
    .stcp_o  (stcp)
  );

  assign oe = oe_q;

endmodule

// File: tb/tb_seg_595_scan.sv
// Directed bench for seg_595_scan: reconstructs each shifted frame from the pins
// and checks it against hand-computed segment tables and timing.
module tb_seg_595_scan;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n;
  logic [23:0] data;
  logic [5:0]  point;
  logic        lz_en;
  logic        blank;
  logic        ds, shcp, stcp, oe;

  seg_595_scan #(
    .DIG_NUM  (6),
    .CLK_FREQ (200_000),
    .SCAN_HZ  (1000),
    .SHCP_DIV (4)
  ) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .data      (data),
    .point     (point),
    .lz_en     (lz_en),
    .blank     (blank),
    .ds        (ds),
    .shcp      (shcp),
    .stcp      (stcp),
    .oe        (oe)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct packed {
    logic [23:0]     data;
    logic [5:0]      point;
    logic            lz;
    logic [5:0][7:0] seg;
  } vec_t;

  typedef struct packed {
    logic [13:0] f;
    int          cyc;
    int          nsh;
    int          first;
  } cap_t;

  vec_t vecs [6];
  cap_t fq [$];
  int   ncmp = 0;
  int   nfail = 0;
  int   cyc = 0;
  int   exp_idx = 0;
  int   last_cyc = -1;

  task automatic chk(input string nm, input int act, input int exp);
    ncmp++;
    if (act != exp) begin
      nfail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Pin monitor: rebuilds frames from ds at shcp rises and logs each stcp rise.
  initial begin
    logic [13:0] shf = '0;
    logic        p_shcp = 1'b0, p_stcp = 1'b0, seen_fall = 1'b0, oe_bad = 1'b0;
    int          nsh = 0, first = 0, rise = 0;
    forever begin
      @(negedge sys_clk);
      if (sys_rst_n !== 1'b1) begin
        cyc = 0; shf = '0; nsh = 0; p_shcp = 1'b0; p_stcp = 1'b0;
        seen_fall = 1'b0; oe_bad = 1'b0;
      end else begin
        cyc++;
        if (!seen_fall && oe !== 1'b1) oe_bad = 1'b1;
        if (shcp && !p_shcp) begin
          if (nsh == 0) first = cyc;
          shf = {ds, shf[13:1]};
          nsh++;
        end
        if (stcp && !p_stcp) begin
          fq.push_back('{shf, cyc, nsh, first});
          nsh  = 0;
          rise = cyc;
        end
        if (!stcp && p_stcp) begin
          chk("stcp_width", cyc - rise, 2);
          if (!seen_fall) chk("oe_dark_before_latch", int'(oe_bad), 0);
          seen_fall = 1'b1;
        end
        p_shcp = shcp;
        p_stcp = stcp;
      end
    end
  end

  task automatic get_frame(output cap_t c, output bit ok);
    int n = 0;
    while (fq.size() == 0 && n < 400) begin
      @(negedge sys_clk);
      #2;
      n++;
    end
    if (fq.size() == 0) begin
      ok = 1'b0;
      c  = '0;
      ncmp++;
      nfail++;
      $display("FAIL frame_timeout: no stcp within %0d cycles", n);
    end else begin
      ok = 1'b1;
      c  = fq.pop_front();
    end
  endtask

  task automatic check_frame(input logic [7:0] eseg, output int s);
    cap_t       c;
    bit         ok;
    logic [5:0] sel_e;
    get_frame(c, ok);
    s = cyc;
    if (ok) begin
      sel_e = 6'd1 << exp_idx;
      s     = c.cyc;
      chk($sformatf("seg_d%0d", exp_idx), int'(c.f[13:6]), int'(eseg));
      chk($sformatf("sel_d%0d", exp_idx), int'(c.f[5:0]), int'(sel_e));
      chk("shcp_per_stcp", c.nsh, 14);
      chk("first_shcp_to_stcp", c.cyc - c.first, 54);
      if (last_cyc < 0) chk("stcp_after_reset", c.cyc, 257);
      else chk("stcp_period", c.cyc - last_cyc, 200);
      last_cyc = c.cyc;
    end
    exp_idx = (exp_idx == 5) ? 0 : exp_idx + 1;
  endtask

  task automatic wait_cyc(input int target);
    while (cyc < target) begin
      @(negedge sys_clk);
      #2;
    end
  endtask

  task automatic apply(input int v);
    data  = vecs[v].data;
    point = vecs[v].point;
    lz_en = vecs[v].lz;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int s;
    vecs[0] = '{24'h012345, 6'b000000, 1'b0, {8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92}};
    vecs[1] = '{24'h012345, 6'b000000, 1'b1, {8'hFF, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92}};
    vecs[2] = '{24'h000000, 6'b000000, 1'b1, {8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hC0}};
    vecs[3] = '{24'h012345, 6'b000100, 1'b0, {8'hC0, 8'hF9, 8'hA4, 8'h30, 8'h99, 8'h92}};
    vecs[4] = '{24'hFEDCBA, 6'b100001, 1'b1, {8'h0E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h08}};
    vecs[5] = '{24'h000900, 6'b100000, 1'b1, {8'h7F, 8'hFF, 8'hFF, 8'h90, 8'hC0, 8'hC0}};

    blank     = 1'b0;
    sys_rst_n = 1'b1;
    apply(0);
    #1 sys_rst_n = 1'b0;
    repeat (3) @(negedge sys_clk);
    chk("rst_ds", int'(ds), 0);
    chk("rst_shcp", int'(shcp), 0);
    chk("rst_stcp", int'(stcp), 0);
    chk("rst_oe", int'(oe), 1);
    #1 sys_rst_n = 1'b1;

    for (int v = 0; v < 6; v++) begin
      apply(v);
      for (int k = 0; k < 6; k++) check_frame(vecs[v].seg[exp_idx], s);
      if (v == 0) chk("oe_lit_after_latch", int'(oe), 0);
    end

    // blank raised in the middle of a shift
    check_frame(vecs[5].seg[exp_idx], s);
    wait_cyc(s + 150);
    chk("oe_before_blank", int'(oe), 0);
    blank = 1'b1;
    @(negedge sys_clk);
    #2;
    chk("oe_blank_1cyc", int'(oe), 1);
    check_frame(vecs[5].seg[exp_idx], s);
    chk("oe_still_blank", int'(oe), 1);
    blank = 1'b0;
    @(negedge sys_clk);
    #2;
    chk("oe_unblank", int'(oe), 0);

    // reset pulsed while bit 7 has shcp high
    check_frame(vecs[5].seg[exp_idx], s);
    wait_cyc(s + 174);
    chk("shcp_high_bit7", int'(shcp), 1);
    sys_rst_n = 1'b0;
    #1;
    chk("midrst_ds", int'(ds), 0);
    chk("midrst_shcp", int'(shcp), 0);
    chk("midrst_stcp", int'(stcp), 0);
    chk("midrst_oe", int'(oe), 1);
    repeat (3) @(negedge sys_clk);
    fq.delete();
    exp_idx  = 0;
    last_cyc = -1;
    #1 sys_rst_n = 1'b1;
    check_frame(vecs[5].seg[exp_idx], s);
    check_frame(vecs[5].seg[exp_idx], s);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
